// File: rtl/pifo_deq_ctrl_if.sv
// pifo_deq_ctrl_if: PIFO min-entry/remove handshake plus the downstream valid/ready stream.
interface pifo_deq_ctrl_if #(
    parameter int RANK_WIDTH = 8,
    parameter int META_WIDTH = 8
);
    logic                  pifo_valid;
    logic [RANK_WIDTH-1:0] pifo_rank;
    logic [META_WIDTH-1:0] pifo_meta;
    logic                  pifo_remove;
    logic                  m_valid;
    logic [RANK_WIDTH-1:0] m_rank;
    logic [META_WIDTH-1:0] m_meta;
    logic                  m_ready;

    modport master (
        input  pifo_valid, pifo_rank, pifo_meta, m_ready,
        output pifo_remove, m_valid, m_rank, m_meta
    );

    modport slave (
        output pifo_valid, pifo_rank, pifo_meta, m_ready,
        input  pifo_remove, m_valid, m_rank, m_meta
    );
endinterface

// File: rtl/pifo_deq_ctrl.sv
// pifo_deq_ctrl: issues guarded remove strobes to a PIFO and buffers removed entries in a 2-deep FIFO.
module pifo_deq_ctrl #(
    parameter int RANK_WIDTH = 8,
    parameter int META_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pifo_deq_ctrl_if.master       bus,
    input  logic                  deq_en,
    input  logic                  limit_en,
    input  logic [RANK_WIDTH-1:0] rank_limit,
    output logic [1:0]            buf_count,
    output logic [CNT_WIDTH-1:0]  deq_count
);
    localparam int W = RANK_WIDTH + META_WIDTH;

    typedef enum logic {ARMED, GUARD} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   slot [2];
    logic           rank_ok, space, pop, remove, wr_idx;

    always_comb begin
        rank_ok   = !limit_en || (bus.pifo_rank <= rank_limit);
        space     = (buf_count != 2'd2) || bus.m_ready;
        pop       = bus.m_valid && bus.m_ready;
        remove    = rst_n && (state == ARMED) && bus.pifo_valid && deq_en && rank_ok && space;
        state_nxt = (state == GUARD) ? ARMED : (remove ? GUARD : ARMED);
        // tail slot after any concurrent pop has shifted the head
        wr_idx    = buf_count[1] || (buf_count[0] && !pop);
    end

    assign bus.pifo_remove           = remove;
    assign bus.m_valid               = buf_count != 2'd0;
    assign {bus.m_rank, bus.m_meta}  = slot[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARMED;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_count <= 2'd0;
            slot[0]   <= '0;
            slot[1]   <= '0;
            deq_count <= '0;
        end else begin
            buf_count <= buf_count + 2'(remove) - 2'(pop);
            if (pop) slot[0] <= slot[1];
            if (remove) begin
                slot[wr_idx] <= {bus.pifo_rank, bus.pifo_meta};
                deq_count    <= deq_count + CNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_pifo_deq_ctrl.sv
// tb_pifo_deq_ctrl: PIFO emulator + queue-based reference model, per-cycle compare and directed scenarios.
module tb_pifo_deq_ctrl;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          deq_en, limit_en;
    logic [7:0]    rank_limit;
    logic [1:0]    buf_count;
    logic [CW-1:0] deq_count;

    pifo_deq_ctrl_if #(.RANK_WIDTH(8), .META_WIDTH(8)) bus ();

    pifo_deq_ctrl #(.RANK_WIDTH(8), .META_WIDTH(8), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .deq_en     (deq_en),
        .limit_en   (limit_en),
        .rank_limit (rank_limit),
        .buf_count  (buf_count),
        .deq_count  (deq_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [15:0] pq[$];
    logic [15:0] bq[$];
    logic [7:0]  acc[$];
    logic [CW-1:0] cnt = '0;
    bit guard = 0, busy = 0, ins_pending = 0;
    int ins_r = 0, rm_seen = 0;
    bit s_rm = 0, s_pop = 0;
    logic [15:0] s_ent = '0;
    bit exp_rm;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void pq_ins(input int r);
        logic [15:0] e = {8'(r), 8'(r) ^ 8'h5A};
        int i = 0;
        while (i < pq.size() && pq[i][15:8] <= 8'(r)) i++;
        pq.insert(i, e);
    endfunction

    function automatic logic [31:0] accv(input int i);
        return (i < acc.size()) ? 32'(acc[i]) : 32'hFFFF;
    endfunction

    // Reference check, away from the active edge; snapshot feeds the model update.
    always @(negedge clk) begin
        exp_rm = rst_n && !guard && bus.pifo_valid && deq_en &&
                 (!limit_en || bus.pifo_rank <= rank_limit) &&
                 (bq.size() < 2 || bus.m_ready);
        chk("pifo_remove", 32'(bus.pifo_remove), 32'(exp_rm));
        chk("m_valid", 32'(bus.m_valid), 32'(rst_n && bq.size() > 0));
        chk("buf_count", 32'(buf_count), rst_n ? 32'(bq.size()) : 32'd0);
        chk("deq_count", 32'(deq_count), rst_n ? 32'(cnt) : 32'd0);
        if (!rst_n || bq.size() > 0)
            chk("m_head", 32'({bus.m_rank, bus.m_meta}), rst_n ? 32'(bq[0]) : 32'd0);
        s_rm  = exp_rm;
        s_pop = rst_n && bq.size() > 0 && bus.m_ready;
        s_ent = {bus.pifo_rank, bus.pifo_meta};
        if (rst_n && bus.m_valid && bus.m_ready) acc.push_back(bus.m_rank);
        if (bus.pifo_remove) rm_seen++;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            bq.delete();
            guard = 0; busy = 0; ins_pending = 0; cnt = '0;
        end else begin
            if (s_pop) void'(bq.pop_front());
            if (s_rm) begin
                bq.push_back(s_ent);
                if (pq.size() > 0) void'(pq.pop_front());
                cnt = cnt + 1'b1;
            end
            guard = s_rm;
            busy  = s_rm;
            if (ins_pending) begin
                pq_ins(ins_r);
                ins_pending = 0;
                busy = 1;
            end
        end
        bus.pifo_valid = !busy && pq.size() > 0;
        {bus.pifo_rank, bus.pifo_meta} = (pq.size() > 0) ? pq[0] : 16'h0;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int n = 0;
        while ((pq.size() != 0 || bq.size() != 0 || ins_pending) && n < maxc) begin
            cyc(1);
            n++;
        end
        chk(nm, 32'(pq.size() == 0 && bq.size() == 0), 32'd1);
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; deq_en = 1'b0; limit_en = 1'b0; rank_limit = 8'd0;
        bus.m_ready = 1'b0; bus.pifo_valid = 1'b1; bus.pifo_rank = 8'd1; bus.pifo_meta = 8'd1;
        #3;
        chk("rst_remove", 32'(bus.pifo_remove), 0);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_buf_count", 32'(buf_count), 0);
        chk("rst_deq_count", 32'(deq_count), 0);
        chk("rst_head", 32'({bus.m_rank, bus.m_meta}), 0);
        cyc(3);
        rst_n = 1'b1;

        // single dequeue
        bus.m_ready = 1'b1;
        pq_ins(5); pq_ins(2); pq_ins(9);
        cyc(2);
        deq_en = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.pifo_remove && k < 10) begin @(negedge clk); k++; end
        chk("t1_remove", 32'(bus.pifo_remove), 1);
        chk("t1_rank_at_remove", 32'(bus.pifo_rank), 2);
        @(negedge clk);
        chk("t1_m_valid", 32'(bus.m_valid), 1);
        chk("t1_m_rank", 32'(bus.m_rank), 2);
        chk("t1_m_meta", 32'(bus.m_meta), 32'(8'd2 ^ 8'h5A));
        wait_idle("t1_idle", 50);
        chk("t1_n", 32'(acc.size()), 3);
        chk("t1_a1", accv(1), 5);
        chk("t1_a2", accv(2), 9);
        chk("t1_count", 32'(deq_count), 3);

        // backpressure
        acc.delete();
        bus.m_ready = 1'b0;
        pq_ins(7); pq_ins(3); pq_ins(6); pq_ins(1);
        cyc(12);
        chk("bp_buf_full", 32'(buf_count), 2);
        chk("bp_count", 32'(deq_count), 5);
        chk("bp_no_remove", 32'(bus.pifo_remove), 0);
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("bp_remove_pop", 32'(bus.pifo_remove), 1);
        chk("bp_rank", 32'(bus.pifo_rank), 6);
        @(negedge clk);
        chk("bp_buf_stays", 32'(buf_count), 2);
        wait_idle("bp_idle", 50);
        chk("bp_n", 32'(acc.size()), 4);
        chk("bp_a0", accv(0), 1);
        chk("bp_a1", accv(1), 3);
        chk("bp_a2", accv(2), 6);
        chk("bp_a3", accv(3), 7);

        // rank limit
        acc.delete();
        limit_en = 1'b1; rank_limit = 8'd3;
        pq_ins(1); pq_ins(4);
        cyc(10);
        chk("rl_n", 32'(acc.size()), 1);
        chk("rl_a0", accv(0), 1);
        chk("rl_held", 32'(bus.pifo_valid && bus.pifo_rank == 8'd4), 1);
        rank_limit = 8'd4;
        wait_idle("rl_idle", 50);
        chk("rl_a1", accv(1), 4);
        chk("rl_count", 32'(deq_count), 9);
        limit_en = 1'b0;

        // concurrent insert during remove
        acc.delete();
        deq_en = 1'b0;
        pq_ins(3); pq_ins(8);
        cyc(2);
        deq_en = 1'b1;
        ins_r = 0; ins_pending = 1;
        wait_idle("ci_idle", 50);
        chk("ci_a0", accv(0), 3);
        chk("ci_a1", accv(1), 0);
        chk("ci_a2", accv(2), 8);
        chk("ci_count", 32'(deq_count), 12);

        // enable off
        acc.delete();
        deq_en = 1'b0;
        pq_ins(2); pq_ins(6);
        rm_seen = 0;
        cyc(20);
        chk("en_no_remove", 32'(rm_seen), 0);
        deq_en = 1'b1;
        wait_idle("en_idle", 50);
        chk("en_a0", accv(0), 2);
        chk("en_a1", accv(1), 6);
        chk("en_count", 32'(deq_count), 14);

        // async reset with a full buffer
        bus.m_ready = 1'b0;
        pq_ins(9); pq_ins(10); pq_ins(11);
        cyc(10);
        chk("ar_full", 32'(buf_count), 2);
        #1;
        rst_n = 1'b0;
        pq.delete();
        #1;
        chk("ar_m_valid", 32'(bus.m_valid), 0);
        chk("ar_buf_count", 32'(buf_count), 0);
        chk("ar_deq_count", 32'(deq_count), 0);
        chk("ar_head", 32'({bus.m_rank, bus.m_meta}), 0);
        chk("ar_remove", 32'(bus.pifo_remove), 0);
        cyc(2);
        rst_n = 1'b1;

        // resume and counter wrap: 16 removes
        acc.delete();
        bus.m_ready = 1'b1;
        for (int i = 15; i >= 0; i--) pq_ins(i);
        wait_idle("wr_idle", 200);
        chk("wr_count", 32'(deq_count), 0);
        chk("wr_n", 32'(acc.size()), 16);
        chk("wr_a0", accv(0), 0);
        chk("wr_a15", accv(15), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pifo_deq_ctrl.md
# pifo_deq_ctrl

Dequeue-side controller for the register-based PIFO. It watches the PIFO's min-entry outputs and issues single-cycle `remove` pulses. Each removed rank/meta pair is captured into a 2-entry output buffer that feeds a downstream valid/ready consumer, such as an output-queue arbiter. Dequeue is gated by an enable, an optional rank limit (calendar-style release) and downstream backpressure, and the block keeps a running dequeue count.

## Interface
- `RANK_WIDTH`, 8, rank width; must match the PIFO.
- `META_WIDTH`, 8, metadata width; must match the PIFO.
- `CNT_WIDTH`, 32, width of the dequeue counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pifo_valid`  in  1  PIFO min-output valid.
- `pifo_rank`  in  RANK_WIDTH  PIFO current min rank.
- `pifo_meta`  in  META_WIDTH  PIFO current min metadata.
- `pifo_remove`  out  1  remove strobe to the PIFO; combinational from state and inputs.
- `deq_en`  in  1  dequeue enable; when 0, no new removes are issued.
- `limit_en`  in  1  enables rank gating.
- `rank_limit`  in  RANK_WIDTH  remove only when `pifo_rank <= rank_limit` (unsigned).
- `m_valid`  out  1  output buffer head valid.
- `m_rank`  out  RANK_WIDTH  head rank.
- `m_meta`  out  META_WIDTH  head metadata.
- `m_ready`  in  1  downstream accepts the head.
- `buf_count`  out  2  output buffer occupancy, 0..2.
- `deq_count`  out  CNT_WIDTH  total removes issued; wraps modulo 2^CNT_WIDTH.

## Operation
- **FSM states.**
  - ARMED: may remove.
  - GUARD: one cycle after every remove; `pifo_remove` is forced to 0.
  - Transitions: ARMED→GUARD when `pifo_remove`=1. GUARD→ARMED unconditionally.
- **Remove condition.** `pifo_remove = (state==ARMED) & pifo_valid & deq_en & (!limit_en | pifo_rank<=rank_limit) & space`.
  - `space = (buf_count<2) | (buf_count==2 & m_ready)`. The "full but popping" case counts as space.
- **Capture.** On the edge where `pifo_remove`=1, `pifo_rank`/`pifo_meta` are written into the buffer tail, in the same cycle the strobe is seen. There is no registered copy of the PIFO outputs, so a concurrent PIFO insert cannot cause a mismatch.
- **Output buffer.** 2-entry FIFO with in-order head.
  - Pop occurs when `m_valid & m_ready`.
  - Simultaneous push and pop: occupancy is unchanged, and data stays ordered.
  - `m_rank`/`m_meta` hold steady while `m_valid`=1 and `m_ready`=0.
- **Counter.** `deq_count` increments by 1 on each edge with `pifo_remove`=1 and wraps to 0 after all-ones.
- **Ignored states.**
  - `pifo_valid`=0 (PIFO empty, or recalculating after an insert or remove): no removal.
  - `deq_en`=0: no removal. Buffered entries still drain.
  - Rank limit not met: no removal and no state change.

## Timing
- **Reset** (asynchronous assert, synchronous deassert by the upstream reset sync):
  - state = ARMED;
  - `m_valid`=0, `buf_count`=0, `deq_count`=0;
  - `m_rank`=0, `m_meta`=0;
  - `pifo_remove`=0 while `rst_n`=0.
- **Latency:** `pifo_remove` in cycle t → `m_valid`=1 in cycle t+1 (if the buffer was empty).
- **Removal rate:** the PIFO drops valid in t+1 and revalidates in t+2. The GUARD state guarantees at most one remove per 2 cycles, so the peak rate is 1 per 2 cycles.
- **Reset mid-operation:** buffered entries are discarded (not returned to the PIFO), and the FSM returns to ARMED. The PIFO must be reset together with this block.
- **`deq_en` deasserted in GUARD:** the block still transitions to ARMED, and no further removes are issued.

## Test plan
- **Single dequeue.** PIFO holds ranks {5,2,9}; `deq_en`=1, `m_ready`=1.
  - `pifo_remove` at cycle t with rank 2.
  - `m_valid`=1, `m_rank`=2 at t+1.
  - Then 5, then 9, each spaced ≥2 cycles.
  - `deq_count`=3, and the PIFO ends empty.
- **Backpressure.** `m_ready`=0 with 4 entries in the PIFO.
  - Exactly 2 removes occur; `buf_count`=2; `pifo_remove` then stays 0.
  - With `m_ready`=1 in the full state, a remove and a pop occur in the same cycle, and `buf_count` stays 2.
- **Rank limit.** `limit_en`=1, `rank_limit`=3, PIFO {1,4}.
  - Only rank 1 is dequeued.
  - Raising `rank_limit` to 4 releases rank 4 at the next ARMED cycle with valid.
- **Concurrent insert.** PIFO insert of rank 0 in the same cycle as a remove of rank 3.
  - `m_rank`=3.
  - The next removal yields 0.
- **Counter wrap and enable.**
  - `CNT_WIDTH`=4: 16 removes leave `deq_count`=0.
  - `deq_en`=0 with a non-empty PIFO: no `pifo_remove` for 20 cycles.
- **Async reset.** Assert `rst_n`=0 mid-stream with `buf_count`=2.
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, the block resumes in ARMED.
